// File: rtl/mult_engine_if.sv
// Request/result bundle for mult_engine; the signed_op line exists only when MULT_SIGNED_EN is defined.
interface mult_engine_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic                 mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
`ifdef MULT_SIGNED_EN
    logic                 signed_op;
`endif
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [6:0]           seg;

    modport master (
`ifdef MULT_SIGNED_EN
        output signed_op,
`endif
        output start, mode, a, b,
        input  busy, done, product, seg
    );

    modport slave (
`ifdef MULT_SIGNED_EN
        input  signed_op,
`endif
        input  start, mode, a, b,
        output busy, done, product, seg
    );
endinterface

// File: rtl/mult_engine.sv
// WIDTH x WIDTH multiplier: one-cycle array multiply or WIDTH-cycle shift-add, start/busy/done handshake.
// Optional two's-complement operation is compiled in with MULT_SIGNED_EN.
module mult_engine #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    mult_engine_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_S     = 7'b0010010;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            sgn_q, sgn_d;
    logic [PW-1:0]   product_q, product_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [6:0]      seg_q, seg_d;

    logic            signed_in;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_next;
    logic [PW-1:0]   mplier_ext;
    logic [PW-1:0]   comb_prod;
    logic            last_bit;

`ifdef MULT_SIGNED_EN
    assign signed_in = bus.signed_op;
`else
    assign signed_in = 1'b0;
`endif

    // Partial product for the current multiplier bit: the shifted multiplicand gated by that bit.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_addend
            assign addend[gi] = mcand_q[gi] & mplier_q[0];
        end
    endgenerate

    // The multiplier's top bit carries negative weight in two's complement, so it is subtracted.
    assign last_bit   = (cnt_q == CW'(WIDTH - 1));
    assign acc_next   = (last_bit && sgn_q) ? (acc_q - addend) : (acc_q + addend);
    assign mplier_ext = {{WIDTH{sgn_q & mplier_q[WIDTH-1]}}, mplier_q};
    assign comb_prod  = mcand_q * mplier_ext;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        sgn_d     = sgn_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        seg_d     = seg_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = CALC;
                    mcand_d  = {{WIDTH{signed_in & bus.a[WIDTH-1]}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    mode_d   = bus.mode;
                    sgn_d    = signed_in;
                    busy_d   = 1'b1;
                    seg_d    = SEG_DASH;
                end
            end
            CALC: begin
                if (mode_q) begin
                    state_d   = DONE;
                    product_d = comb_prod;
                    done_d    = 1'b1;
                    seg_d     = SEG_C;
                end else begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (last_bit) begin
                        state_d   = DONE;
                        product_d = acc_next;
                        done_d    = 1'b1;
                        seg_d     = SEG_S;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            sgn_q     <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            sgn_q     <= sgn_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.seg     = seg_q;
endmodule

// File: doc/mult_engine.md
# mult_engine

Parametrised multiplier engine: the next generation of the board-level sequential/combinational multiplier. It accepts a WIDTH×WIDTH multiply through a start/busy/done handshake and computes it either with a single-cycle array multiply or with a WIDTH-cycle shift-add datapath. The result is held in an output register, and a 7-segment status code is driven for the board display. It sits between the switch/button input logic and the result LEDs/display.

## Interface
- WIDTH, 8, operand width in bits; legal values are ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clock is clk.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = sequential shift-add, 1 = combinational; latched at accept.
- a  in  WIDTH  multiplicand; latched at accept.
- b  in  WIDTH  multiplier; latched at accept.
- signed_op  in  1  two's-complement operands; present only with MULT_SIGNED_EN; latched at accept.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when product updates.
- product  out  2*WIDTH  registered result; held until the next completion.
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE → CALC: start=1 at an edge. a, b, mode (and signed_op) are latched at that edge; this is the "accept".
  - CALC → DONE: after 1 cycle when mode=1, or after WIDTH cycles when mode=0.
  - DONE → IDLE: unconditionally after 1 cycle.
- start is ignored in CALC and DONE. Input changes after accept have no effect on the operation in flight.
- Sequential mode processes one multiplier bit per CALC cycle, LSB first, using an add-and-shift accumulator of 2*WIDTH bits.
  - Latency is always exactly WIDTH cycles. There is no early termination for zero or small operands.
- Combinational mode computes the latched a*b in the single CALC cycle.
- product is written only on the CALC→DONE edge. It is not cleared by start.
- Arithmetic is unsigned with a full 2*WIDTH result, so no overflow is possible.
- done is high exactly during the DONE state.
- seg codes:
  - After reset: 7'b1111111 (blank).
  - While in CALC: 7'b0111111 ("-").
  - From DONE until the next accept: "C" 7'b1000110 if the last operation was combinational, "S" 7'b0010010 if it was sequential.
- Reset is asynchronous and may occur mid-operation. All outputs go to reset values immediately and the FSM returns to IDLE. No partial result is written.

## Timing
- Reset values: busy=0, done=0, product=0, seg=7'b1111111, state=IDLE.
- Accept at edge N:
  - busy is high from edge N.
  - product is valid and done=1 after edge N+L, where L=1 (mode=1) or L=WIDTH (mode=0).
  - busy falls at edge N+L+1.
- The total busy window is L+1 cycles. The earliest next accept is edge N+L+2, which requires start high in the IDLE cycle.
- start held high continuously gives back-to-back operations every L+2 cycles.

## Configuration
- MULT_SIGNED_EN defined:
  - The signed_op port exists.
  - signed_op=1 treats a and b as two's complement and produces a two's-complement 2*WIDTH product.
  - Latency is identical to unsigned in both modes; the sequential path must not add cycles.
- MULT_SIGNED_EN undefined: the signed_op port is absent and all arithmetic is unsigned.

## Test plan
- **Combinational multiply.** WIDTH=8, mode=1, a=13, b=11, start pulsed for 1 cycle → done one cycle after accept, product=16'd143, busy high 2 cycles, seg=7'b1000110.
- **Sequential multiply.** mode=0, a=255, b=255 → done exactly 8 cycles after accept, product=16'd65025, busy high 9 cycles, seg=7'b0111111 during CALC then 7'b0010010.
- **Start ignored while busy.** Accept a=7, b=6 (mode=0); re-pulse start with a=0 during CALC → product=42, only one done pulse.
- **Reset mid-operation.** Assert reset 4 cycles into a mode=0 operation → product=0, busy=0, seg blank immediately without waiting for clk. A following mode=1 operation a=3, b=3 gives product 9.
- **Signed mode (MULT_SIGNED_EN).** a=8'hFD, b=8'h05, signed_op=1 → product=16'hFFF1 in both modes. With signed_op=0 → 16'h04F1.
- **Wide unsigned.** WIDTH=16, mode=0, a=16'hFFFF, b=2 → product=32'h0001FFFE after exactly 16 cycles.
